// File: rtl/elevator_scheduler.sv
`default_nettype none
// ============================================================================
// elevator_scheduler : collective-direction scheduler for a 10-floor elevator
// Revision 1.0
// ============================================================================
module elevator_scheduler #(
  parameter int FLOOR_TIME = 16,
  parameter int DOOR_TIME  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] req,
  output logic [9:0] clr,
  output logic [3:0] floor,
  output logic       motor_up,
  output logic       motor_down,
  output logic       door_open,
  output logic       busy
);

  localparam int          c_MAXT     = (FLOOR_TIME > DOOR_TIME) ? FLOOR_TIME : DOOR_TIME;
  localparam int          c_TW       = $clog2(c_MAXT);
  localparam logic [3:0]  c_TOP      = 4'd9;
  localparam logic        c_DIR_UP   = 1'b1;
  localparam logic        c_DIR_DOWN = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_UP   = 2'd1,
    S_DOWN = 2'd2,
    S_DOOR = 2'd3
  } state_t;

  state_t            r_state;
  logic [3:0]        r_floor;
  logic              r_dir;
  logic [c_TW-1:0]   r_timer;
  logic [9:0]        r_clr;
  logic              r_motor_up;
  logic              r_motor_down;
  logic              r_door_open;
  logic              r_busy;

  state_t            w_state_nxt;
  logic [3:0]        w_floor_nxt;
  logic              w_dir_nxt;
  logic [c_TW-1:0]   w_timer_nxt;
  logic [3:0]        w_up1;
  logic [3:0]        w_dn1;
  logic              w_here;
  logic              w_above;
  logic              w_below;
  logic              w_here_up1;
  logic              w_above_up1;
  logic              w_here_dn1;
  logic              w_below_dn1;

  assign w_up1 = r_floor + 4'd1;
  assign w_dn1 = r_floor - 4'd1;

  // Request summaries relative to the current floor and the floor being approached
  always_comb begin
    w_here      = 1'b0;
    w_above     = 1'b0;
    w_below     = 1'b0;
    w_here_up1  = 1'b0;
    w_above_up1 = 1'b0;
    w_here_dn1  = 1'b0;
    w_below_dn1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (4'(i) == r_floor) w_here      = w_here      | req[i];
      if (4'(i) >  r_floor) w_above     = w_above     | req[i];
      if (4'(i) <  r_floor) w_below     = w_below     | req[i];
      if (4'(i) == w_up1)   w_here_up1  = w_here_up1  | req[i];
      if (4'(i) >  w_up1)   w_above_up1 = w_above_up1 | req[i];
      if (4'(i) == w_dn1)   w_here_dn1  = w_here_dn1  | req[i];
      if (4'(i) <  w_dn1)   w_below_dn1 = w_below_dn1 | req[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_dir_nxt   = r_dir;
    w_timer_nxt = r_timer + 1'b1;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_here) begin
          w_state_nxt = S_DOOR;
        end else if (r_dir == c_DIR_UP) begin
          if (w_above) begin
            w_state_nxt = S_UP;
          end else if (w_below) begin
            w_state_nxt = S_DOWN;
            w_dir_nxt   = c_DIR_DOWN;
          end
        end else begin
          if (w_below) begin
            w_state_nxt = S_DOWN;
          end else if (w_above) begin
            w_state_nxt = S_UP;
            w_dir_nxt   = c_DIR_UP;
          end
        end
      end
      S_UP: begin
        if (r_timer == c_TW'(FLOOR_TIME - 1)) begin
          w_timer_nxt = '0;
          if (r_floor < c_TOP) begin
            w_floor_nxt = w_up1;
            if (w_here_up1)       w_state_nxt = S_DOOR;
            else if (w_above_up1) w_state_nxt = S_UP;
            else                  w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DOWN: begin
        if (r_timer == c_TW'(FLOOR_TIME - 1)) begin
          w_timer_nxt = '0;
          if (r_floor > 4'd0) begin
            w_floor_nxt = w_dn1;
            if (w_here_dn1)       w_state_nxt = S_DOOR;
            else if (w_below_dn1) w_state_nxt = S_DOWN;
            else                  w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DOOR: begin
        if (r_timer == c_TW'(DOOR_TIME - 1)) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_timer_nxt = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_floor      <= 4'd0;
      r_dir        <= c_DIR_UP;
      r_timer      <= '0;
      r_clr        <= '0;
      r_motor_up   <= 1'b0;
      r_motor_down <= 1'b0;
      r_door_open  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_floor      <= w_floor_nxt;
      r_dir        <= w_dir_nxt;
      r_timer      <= w_timer_nxt;
      r_clr        <= (w_state_nxt == S_DOOR) ? (10'd1 << w_floor_nxt) : 10'd0;
      r_motor_up   <= (w_state_nxt == S_UP);
      r_motor_down <= (w_state_nxt == S_DOWN);
      r_door_open  <= (w_state_nxt == S_DOOR);
      r_busy       <= (w_state_nxt != S_IDLE);
    end
  end

  assign clr        = r_clr;
  assign floor      = r_floor;
  assign motor_up   = r_motor_up;
  assign motor_down = r_motor_down;
  assign door_open  = r_door_open;
  assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_elevator_scheduler.sv
`default_nettype none
// ============================================================================
// tb_elevator_scheduler : directed scoreboard bench for elevator_scheduler
// Revision 1.0
// ============================================================================
module tb_elevator_scheduler;

  localparam int c_FT = 16;
  localparam int c_DT = 8;

  logic       clk;
  logic       reset;
  logic [9:0] req_reg;
  logic [9:0] press;
  logic [9:0] withdraw;
  logic [9:0] clr;
  logic [3:0] floor;
  logic       motor_up;
  logic       motor_down;
  logic       door_open;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int mcnt  = 0;
  int dcnt  = 0;

  typedef struct {
    logic [3:0] f;
    int         m;
  } stop_t;
  stop_t sb[$];

  elevator_scheduler #(.FLOOR_TIME(c_FT), .DOOR_TIME(c_DT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_reg),
    .clr        (clr),
    .floor      (floor),
    .motor_up   (motor_up),
    .motor_down (motor_down),
    .door_open  (door_open),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request register: set by presses, cleared by the scheduler or by withdrawal
  always @(posedge clk) begin
    if (reset) req_reg <= '0;
    else       req_reg <= (req_reg | press) & ~clr & ~withdraw;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_floor(input logic [9:0] m);
    press = m;
    tick();
    press = '0;
  endtask

  task automatic expect_stop(input logic [3:0] f, input int m);
    stop_t s;
    s.f = f;
    s.m = m;
    sb.push_back(s);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || req_reg != 10'd0) && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_wait", {30'd0, busy, |req_reg}, 32'd0);
  endtask

  task automatic wait_move(input logic [3:0] f);
    int n = 0;
    while (!(floor == f && motor_up) && n < 3000) begin
      tick();
      n++;
    end
    chk("move_wait", {27'd0, motor_up, floor}, {27'd0, 1'b1, f});
  endtask

  task automatic wait_door();
    int n = 0;
    while (!door_open && n < 3000) begin
      tick();
      n++;
    end
    chk("door_wait", {31'd0, door_open}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk(tag, {16'd0, clr, floor, motor_up, motor_down, door_open, busy}, 32'd0);
  endtask

  // Monitor: per-cycle invariants and stop scoreboard, sampled on the falling edge
  initial begin
    logic  prev_door;
    stop_t e;
    prev_door = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_door = 1'b0;
        dcnt      = 0;
        mcnt      = 0;
      end else begin
        chk("exclusive_outputs",
            {31'd0, (motor_up & motor_down) | ((motor_up | motor_down) & door_open)}, 32'd0);
        chk("clr_decode", {22'd0, clr}, {22'd0, door_open ? (10'd1 << floor) : 10'd0});
        if (motor_up || motor_down || door_open) chk("busy_active", {31'd0, busy}, 32'd1);
        if (motor_up || motor_down) mcnt++;
        if (door_open && !prev_door) begin
          if (sb.size() == 0) begin
            chk("unexpected_stop", {28'd0, floor}, 32'hFFFF);
          end else begin
            e = sb.pop_front();
            chk("stop_floor", {28'd0, floor}, {28'd0, e.f});
            chk("stop_motor_cycles", mcnt, e.m);
          end
          mcnt = 0;
          dcnt = 0;
        end
        if (door_open) dcnt++;
        if (!door_open && prev_door) chk("door_cycles", dcnt, c_DT);
        prev_door = door_open;
      end
    end
  end

  initial begin
    reset    = 1'b1;
    press    = '0;
    withdraw = '0;
    repeat (3) tick();
    chk_reset_outputs("reset_state");
    reset = 1'b0;

    // Request at the current floor: door opens on the next decision, no motion
    expect_stop(4'd0, 0);
    press_floor(10'h001);
    tick();
    chk("same_floor_door", {20'd0, clr, door_open, motor_up}, {20'd0, 10'h001, 1'b1, 1'b0});
    wait_idle();

    // 0 -> 3 in 3*FLOOR_TIME motor cycles
    expect_stop(4'd3, 3 * c_FT);
    press_floor(10'h008);
    wait_idle();
    chk("arrive_floor3", {27'd0, busy, floor}, {27'd0, 1'b0, 4'd3});

    // Position at floor 5 heading up
    expect_stop(4'd5, 2 * c_FT);
    press_floor(10'h020);
    wait_idle();

    // Floors 3 and 7 pending while heading up at 5: serve 7 first, then 3
    expect_stop(4'd7, 2 * c_FT);
    expect_stop(4'd3, 4 * c_FT);
    press_floor(10'h088);
    wait_idle();

    // Now heading down at 3: floors 1 and 5 pending -> 1 first
    expect_stop(4'd1, 2 * c_FT);
    expect_stop(4'd5, 4 * c_FT);
    press_floor(10'h022);
    wait_idle();

    expect_stop(4'd0, 5 * c_FT);
    press_floor(10'h001);
    wait_idle();

    // Intermediate stop added while travelling 0 -> 6
    press_floor(10'h040);
    wait_move(4'd2);
    expect_stop(4'd4, 4 * c_FT);
    expect_stop(4'd6, 2 * c_FT);
    press_floor(10'h010);
    wait_idle();
    chk("arrive_floor6", {28'd0, floor}, 32'd6);

    expect_stop(4'd0, 6 * c_FT);
    press_floor(10'h001);
    wait_idle();

    // Request withdrawn mid-travel: finish the floor, no door
    press_floor(10'h200);
    wait_move(4'd0);
    withdraw = 10'h200;
    tick();
    withdraw = '0;
    wait_idle();
    chk("withdraw_floor", {28'd0, floor}, 32'd1);
    chk("withdraw_motor_cycles", mcnt, c_FT);

    // Reset while moving up at floor 4
    press_floor(10'h100);
    wait_move(4'd4);
    reset = 1'b1;
    tick();
    chk_reset_outputs("reset_mid_travel");
    reset = 1'b0;

    // Reset while the door is open
    expect_stop(4'd2, 2 * c_FT);
    press_floor(10'h004);
    wait_door();
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("reset_door_open");
    reset = 1'b0;
    repeat (3) tick();
    chk("stays_idle_after_reset", {27'd0, busy, floor}, 32'd0);

    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
